// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction memory request/acknowledge bundle
//
// Purpose: groups the fetch handshake between pc_fetch_unit and instruction memory.
// Signals:
//   imem_req   fetch request, driven by the fetch unit
//   imem_addr  fetch address, driven by the fetch unit
//   imem_ack   memory returns data this cycle, driven by memory
//   imem_rdata instruction word, valid when imem_ack=1, driven by memory
// Modports: master = fetch unit side, slave = memory side.

interface pc_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - architectural PC register with handshaked, stallable instruction fetch
//
// Purpose: holds the PC, fetches the instruction at PC over a req/ack handshake,
// presents it to decode/next-PC logic and loads the next PC on commit.
// Ports:
//   clk        system clock, all state updates on rising edge
//   rst        synchronous active-high reset
//   imem       instruction memory handshake (master side)
//   npc        next PC computed from current pc/Ins
//   commit     current instruction done; load npc into PC
//   stall      hold current instruction; overrides commit
//   pc         current instruction address
//   Ins        latched instruction word
//   ins_valid  Ins valid for decode and next-PC logic
//   fault      sticky fault flag (misaligned npc or fetch timeout)
//   fault_pc   offending address
//   retired    count of committed instructions
// Every output comes straight from a register.

module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'h0000_3000,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   pc_fetch_unit_if.master        imem,
   input  logic [31:0]            npc,
   input  logic                   commit,
   input  logic                   stall,
   output logic [31:0]            pc,
   output logic [31:0]            Ins,
   output logic                   ins_valid,
   output logic                   fault,
   output logic [31:0]            fault_pc,
   output logic [31:0]            retired
);

   typedef enum logic [1:0] {
      S_BOOT,
      S_REQ,
      S_HOLD,
      S_FAULT
   } state_t;

   // Last wait-counter value before the request is declared dead.
   localparam logic [7:0] CNT_LAST = 8'(ACK_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ins_q, ins_d;
   logic        valid_q, valid_d;
   logic        req_q, req_d;
   logic        fault_q, fault_d;
   logic [31:0] fpc_q, fpc_d;
   logic [31:0] ret_q, ret_d;
   logic [7:0]  cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_PC;
         ins_q   <= 32'h0;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
         fault_q <= 1'b0;
         fpc_q   <= 32'h0;
         ret_q   <= 32'h0;
         cnt_q   <= 8'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ins_q   <= ins_d;
         valid_q <= valid_d;
         req_q   <= req_d;
         fault_q <= fault_d;
         fpc_q   <= fpc_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
      end
   end

   // imem_req is registered, so it is raised on the transition into S_REQ
   // and dropped on the transition out of it.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ins_d   = ins_q;
      valid_d = valid_q;
      req_d   = req_q;
      fault_d = fault_q;
      fpc_d   = fpc_q;
      ret_d   = ret_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_BOOT: begin
            state_d = S_REQ;
            req_d   = 1'b1;
            cnt_d   = 8'h0;
         end
         S_REQ: begin
            if (imem.imem_ack) begin
               ins_d   = imem.imem_rdata;
               valid_d = 1'b1;
               req_d   = 1'b0;
               cnt_d   = 8'h0;
               state_d = S_HOLD;
            end else if (cnt_q == CNT_LAST) begin
               fault_d = 1'b1;
               fpc_d   = pc_q;
               req_d   = 1'b0;
               state_d = S_FAULT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_HOLD: begin
            if (commit && !stall) begin
               valid_d = 1'b0;
               if (npc[1:0] == 2'b00) begin
                  pc_d    = npc;
                  ret_d   = ret_q + 32'd1;
                  req_d   = 1'b1;
                  cnt_d   = 8'h0;
                  state_d = S_REQ;
               end else begin
                  fault_d = 1'b1;
                  fpc_d   = npc;
                  state_d = S_FAULT;
               end
            end
         end
         S_FAULT: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign pc             = pc_q;
   assign Ins            = ins_q;
   assign ins_valid      = valid_q;
   assign fault          = fault_q;
   assign fault_pc       = fpc_q;
   assign retired        = ret_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed vector bench for pc_fetch_unit

module tb_pc_fetch_unit;

   logic        clk;
   logic        rst;
   logic [31:0] npc;
   logic        commit;
   logic        stall;
   logic [31:0] pc;
   logic [31:0] Ins;
   logic        ins_valid;
   logic        fault;
   logic [31:0] fault_pc;
   logic [31:0] retired;

   int n_cmp = 0;
   int n_err = 0;

   pc_fetch_unit_if imem ();

   pc_fetch_unit #(
      .RESET_PC    (32'h0000_3000),
      .ACK_TIMEOUT (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .imem      (imem),
      .npc       (npc),
      .commit    (commit),
      .stall     (stall),
      .pc        (pc),
      .Ins       (Ins),
      .ins_valid (ins_valid),
      .fault     (fault),
      .fault_pc  (fault_pc),
      .retired   (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        commit;
      logic        stall;
      logic [31:0] npc;
      logic        ack;
      logic [31:0] rdata;
      logic        e_req;
      logic        e_valid;
      logic        e_fault;
      logic [31:0] e_pc;
      logic [31:0] e_ins;
      logic [31:0] e_fpc;
      logic [31:0] e_ret;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(logic r, logic c, logic s, logic [31:0] n, logic a, logic [31:0] d,
                               logic eq, logic ev, logic ef, logic [31:0] ep, logic [31:0] ei,
                               logic [31:0] efp, logic [31:0] er);
      vec_t v;
      v.rst = r; v.commit = c; v.stall = s; v.npc = n; v.ack = a; v.rdata = d;
      v.e_req = eq; v.e_valid = ev; v.e_fault = ef; v.e_pc = ep; v.e_ins = ei;
      v.e_fpc = efp; v.e_ret = er;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Apply inputs for the next rising edge, then step past it.
   task automatic step(input logic r, input logic c, input logic s, input logic [31:0] n,
                       input logic a, input logic [31:0] d);
      rst = r; commit = c; stall = s; npc = n;
      imem.imem_ack = a; imem.imem_rdata = d;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic eq, input logic ev, input logic ef,
                          input logic [31:0] ep, input logic [31:0] ei, input logic [31:0] efp,
                          input logic [31:0] er);
      chk({tag, ".req"},      32'(imem.imem_req), 32'(eq));
      chk({tag, ".addr"},     imem.imem_addr, ep);
      chk({tag, ".pc"},       pc, ep);
      chk({tag, ".valid"},    32'(ins_valid), 32'(ev));
      chk({tag, ".ins"},      Ins, ei);
      chk({tag, ".fault"},    32'(fault), 32'(ef));
      chk({tag, ".fault_pc"}, fault_pc, efp);
      chk({tag, ".retired"},  retired, er);
   endtask

   initial begin
      //             rst c s npc           ack rdata          req vld flt pc            ins            fpc           ret
      vecs[0]  = mk(1, 0, 0, 32'h0,        0, 32'h0,         0, 0, 0, 32'h3000, 32'h0,         32'h0,    0);
      vecs[1]  = mk(0, 0, 0, 32'h0,        0, 32'h0,         1, 0, 0, 32'h3000, 32'h0,         32'h0,    0);
      vecs[2]  = mk(0, 0, 0, 32'h0,        1, 32'h2008_0005, 0, 1, 0, 32'h3000, 32'h2008_0005, 32'h0,    0);
      vecs[3]  = mk(0, 1, 0, 32'h3004,     0, 32'h0,         1, 0, 0, 32'h3004, 32'h2008_0005, 32'h0,    1);
      vecs[4]  = mk(0, 0, 0, 32'h0,        1, 32'h8C01_0000, 0, 1, 0, 32'h3004, 32'h8C01_0000, 32'h0,    1);
      vecs[5]  = mk(0, 1, 1, 32'h3010,     0, 32'h0,         0, 1, 0, 32'h3004, 32'h8C01_0000, 32'h0,    1);
      vecs[6]  = mk(0, 1, 1, 32'h3010,     0, 32'h0,         0, 1, 0, 32'h3004, 32'h8C01_0000, 32'h0,    1);
      vecs[7]  = mk(0, 1, 1, 32'h3010,     0, 32'h0,         0, 1, 0, 32'h3004, 32'h8C01_0000, 32'h0,    1);
      vecs[8]  = mk(0, 1, 0, 32'h3010,     0, 32'h0,         1, 0, 0, 32'h3010, 32'h8C01_0000, 32'h0,    2);
      vecs[9]  = mk(0, 0, 0, 32'h0,        1, 32'h1000_FFFF, 0, 1, 0, 32'h3010, 32'h1000_FFFF, 32'h0,    2);
      vecs[10] = mk(0, 0, 0, 32'h0,        1, 32'hFFFF_FFFF, 0, 1, 0, 32'h3010, 32'h1000_FFFF, 32'h0,    2);
      vecs[11] = mk(0, 1, 0, 32'h3010,     0, 32'h0,         1, 0, 0, 32'h3010, 32'h1000_FFFF, 32'h0,    3);
      vecs[12] = mk(0, 0, 0, 32'h0,        1, 32'h2402_0001, 0, 1, 0, 32'h3010, 32'h2402_0001, 32'h0,    3);
      vecs[13] = mk(0, 1, 0, 32'h3012,     0, 32'h0,         0, 0, 1, 32'h3010, 32'h2402_0001, 32'h3012, 3);
      vecs[14] = mk(0, 1, 0, 32'h3020,     1, 32'hFFFF_FFFF, 0, 0, 1, 32'h3010, 32'h2402_0001, 32'h3012, 3);
      vecs[15] = mk(1, 0, 0, 32'h0,        0, 32'h0,         0, 0, 0, 32'h3000, 32'h0,         32'h0,    0);

      for (int i = 0; i < 16; i++) begin
         step(vecs[i].rst, vecs[i].commit, vecs[i].stall, vecs[i].npc, vecs[i].ack, vecs[i].rdata);
         chk_all($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_valid, vecs[i].e_fault,
                 vecs[i].e_pc, vecs[i].e_ins, vecs[i].e_fpc, vecs[i].e_ret);
      end

      // Ack delayed 5 cycles: request and address held, valid rises one cycle after ack.
      step(1, 0, 0, 32'h0, 0, 32'h0);
      step(0, 0, 0, 32'h0, 0, 32'h0);
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 0, 32'h0, 0, 32'hDEAD_0000);
         chk($sformatf("wait%0d.req", k),   32'(imem.imem_req), 32'h1);
         chk($sformatf("wait%0d.addr", k),  imem.imem_addr, 32'h3000);
         chk($sformatf("wait%0d.valid", k), 32'(ins_valid), 32'h0);
      end
      step(0, 0, 0, 32'h0, 1, 32'h0123_4560);
      chk_all("delayed_ack", 0, 1, 0, 32'h3000, 32'h0123_4560, 32'h0, 0);

      // Fetch timeout: no ack for 16 request cycles.
      step(1, 0, 0, 32'h0, 0, 32'h0);
      step(0, 0, 0, 32'h0, 0, 32'h0);
      for (int k = 1; k < 16; k++) begin
         step(0, 0, 0, 32'h0, 0, 32'h0);
         chk($sformatf("to%0d.fault", k), 32'(fault), 32'h0);
         chk($sformatf("to%0d.req", k),   32'(imem.imem_req), 32'h1);
      end
      step(0, 0, 0, 32'h0, 0, 32'h0);
      chk_all("timeout", 0, 0, 1, 32'h3000, 32'h0, 32'h3000, 0);
      step(0, 1, 0, 32'h3004, 1, 32'h1111_1111);
      chk_all("timeout_sticky", 0, 0, 1, 32'h3000, 32'h0, 32'h3000, 0);
      step(1, 0, 0, 32'h0, 0, 32'h0);
      chk_all("timeout_rst", 0, 0, 0, 32'h3000, 32'h0, 32'h0, 0);
      step(0, 0, 0, 32'h0, 0, 32'h0);
      chk_all("timeout_restart", 1, 0, 0, 32'h3000, 32'h0, 32'h0, 0);

      // Reset during REQ with a simultaneous ack: ack ignored, BOOT for one cycle.
      step(1, 0, 0, 32'h0, 1, 32'hDEAD_BEEF);
      chk_all("rst_ack", 0, 0, 0, 32'h3000, 32'h0, 32'h0, 0);
      step(0, 0, 0, 32'h0, 1, 32'hDEAD_BEEF);
      chk_all("rst_boot_exit", 1, 0, 0, 32'h3000, 32'h0, 32'h0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
